// File: rtl/wbmic_pkg.sv
// ============================================================================
// wbmic_pkg : shared encodings for the mic FIFO Wishbone controller
// Revision  : 1.0
// ============================================================================
`default_nettype none

package wbmic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP1  = 3'd1,
    ST_POP2  = 3'd2,
    ST_ACK   = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  localparam logic ADDR_CTRL = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

  localparam int CTRL_OVFL     = 31;
  localparam int CTRL_UNFL     = 30;
  localparam int CTRL_EN       = 29;
  localparam int CTRL_INT      = 28;
  localparam int CTRL_FLUSH    = 28;
  localparam int CTRL_THRESH_H = 27;
  localparam int CTRL_THRESH_L = 16;

endpackage

`default_nettype wire

// File: rtl/wbmic_fifoctl.sv
// ============================================================================
// wbmic_fifoctl : Wishbone controller for the MEMs mic sample FIFO read side
//                 (pop, flush, enable, interrupt). WBMIC_PACK2_EN packs two
//                 samples per DATA read.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module wbmic_fifoctl
  import wbmic_pkg::*;
#(
  parameter int BW           = 12,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic          i_wb_addr,
  input  logic [31:0]   i_wb_data,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic [31:0]   o_wb_data,
  output logic          o_fifo_rd,
  output logic          o_fifo_rst,
  input  logic          i_fifo_empty_n,
  input  logic [BW-1:0] i_fifo_data,
  input  logic [15:0]   i_fifo_status,
  input  logic          i_fifo_err,
  output logic          o_mic_en,
  output logic          o_int
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic [11:0]   thresh_q, thresh_d;
  logic          ovfl_q, ovfl_d;
  logic          unfl_q, unfl_d;
  logic          int_q, int_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef WBMIC_PACK2_EN
  logic [14:0]   s0_q, s0_d;
  logic          v0_q, v0_d;
`endif

  logic          accept;
  logic [13:0]   fill;
  logic [14:0]   head;
  logic [31:0]   ctrl_word;
  logic          unused_wdata;

  assign accept       = (state_q == ST_IDLE) & i_wb_cyc & i_wb_stb;
  assign fill         = i_fifo_status[15:2];
  // Invalid pops present a zero sample rather than whatever the FIFO head shows.
  assign head         = i_fifo_empty_n ? 15'(i_fifo_data) : 15'd0;
  assign ctrl_word    = {ovfl_q, unfl_q, en_q, int_q, thresh_q, i_fifo_status};
  assign unused_wdata = ^i_wb_data[15:0];

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    thresh_d   = thresh_q;
    ovfl_d     = ovfl_q;
    unfl_d     = unfl_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
`ifdef WBMIC_PACK2_EN
    s0_d       = s0_q;
    v0_d       = v0_q;
`endif
    o_fifo_rd  = 1'b0;
    o_fifo_rst = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (i_wb_addr == ADDR_CTRL) begin
            if (i_wb_we) begin
              if (i_wb_data[CTRL_OVFL]) ovfl_d = 1'b0;
              if (i_wb_data[CTRL_UNFL]) unfl_d = 1'b0;
              en_d     = i_wb_data[CTRL_EN];
              thresh_d = i_wb_data[CTRL_THRESH_H:CTRL_THRESH_L];
              if (i_wb_data[CTRL_FLUSH]) begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
              end else begin
                state_d = ST_ACK;
              end
            end else begin
              rdata_d = ctrl_word;
              state_d = ST_ACK;
            end
          end else if (i_wb_we) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_POP1;
          end
        end
      end

      ST_POP1: begin
        o_fifo_rd = i_fifo_empty_n;
        if (!i_fifo_empty_n) unfl_d = 1'b1;
`ifdef WBMIC_PACK2_EN
        s0_d    = head;
        v0_d    = i_fifo_empty_n;
        state_d = ST_POP2;
`else
        rdata_d = {i_fifo_empty_n, 31'(head)};
        state_d = ST_ACK;
`endif
      end

`ifdef WBMIC_PACK2_EN
      ST_POP2: begin
        o_fifo_rd = i_fifo_empty_n;
        if (!i_fifo_empty_n) unfl_d = 1'b1;
        rdata_d   = {v0_q, s0_q, i_fifo_empty_n, head};
        state_d   = ST_ACK;
      end
`endif

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      ST_FLUSH: begin
        if (cnt_q == '0) begin
          o_fifo_rst = 1'b1;
          ovfl_d     = 1'b0;
          unfl_d     = 1'b0;
        end
        if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new overflow wins over any clear in the same cycle.
    if (i_fifo_err) ovfl_d = 1'b1;

    int_d = en_q & (((thresh_q != 12'd0) & (fill >= 14'(thresh_q))) | ovfl_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      thresh_q <= '0;
      ovfl_q   <= 1'b0;
      unfl_q   <= 1'b0;
      int_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
`ifdef WBMIC_PACK2_EN
      s0_q     <= '0;
      v0_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      thresh_q <= thresh_d;
      ovfl_q   <= ovfl_d;
      unfl_q   <= unfl_d;
      int_q    <= int_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
`ifdef WBMIC_PACK2_EN
      s0_q     <= s0_d;
      v0_q     <= v0_d;
`endif
    end
  end

  assign o_wb_stall = (state_q != ST_IDLE);
  assign o_wb_ack   = (state_q == ST_ACK) & i_wb_cyc;
  assign o_wb_data  = rdata_q;
  assign o_mic_en   = en_q;
  assign o_int      = int_q;

endmodule

`default_nettype wire
